// File: rtl/mips32_boot_pkg.sv
// Shared definitions for the MIPS32 program loader.
//   loader_state_t : loader FSM state encoding
//   HDR_BYTES      : bytes in the big-endian word-count header
//   BYTES_PER_WORD : stream bytes per memory word
//   HLT_OPCODE     : CPU halt instruction word, handy for building test programs
package mips32_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_BYTES,
        ST_WRITE,
        ST_START,
        ST_RUN,
        ST_READ,
        ST_RESP,
        ST_ERR
    } loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [31:0] HLT_OPCODE = 32'hfc000000;

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Loader bus bundle: byte stream in, memory port, CPU control, result out.
//   master : the loader (drives in_ready, memory, CPU control, result)
//   slave  : the environment (stream source, memory, CPU, result sink)
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10
) ();

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              cpu_hold;
    logic              cpu_start;
    logic              cpu_halted;

    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;

    modport master (
        input  in_valid, in_data, mem_rdata, cpu_halted, res_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
               res_valid, res_data
    );

    modport slave (
        output in_valid, in_data, mem_rdata, cpu_halted, res_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
               res_valid, res_data
    );

endinterface

// File: rtl/mips32_byte_packer.sv
// Big-endian 8-to-32 assembler.
//   clk1, rst_n            : clock, async active-low reset
//   byte_valid/byte_ready  : a byte is taken when both are high
//   byte_data              : stream byte, first byte lands in word[31:24]
//   word_valid             : high in the cycle the last byte of a word is taken
//   word                   : assembled word, valid with word_valid
module mips32_byte_packer
    import mips32_boot_pkg::*;
(
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic        byte_ready,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CW = $clog2(BYTES_PER_WORD);
    localparam int SW = 8 * (BYTES_PER_WORD - 1);

    logic          accept;
    logic [CW-1:0] cnt;
    logic [SW-1:0] shift;

    assign accept = byte_valid && byte_ready;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shift <= '0;
        end else if (accept) begin
            cnt   <= cnt + CW'(1);
            shift <= {shift[SW-9:0], byte_data};
        end
    end

    // The last byte is merged combinationally so the consumer can write the
    // word on the very next edge, keeping the 5-cycle-per-word pace.
    assign word_valid = accept && (cnt == CW'(BYTES_PER_WORD - 1));
    assign word       = {shift, byte_data};

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader for pipe_MIPS32: loads a byte-stream program into memory,
// releases the CPU, waits for halt, returns the word at RESULT_ADDR.
//   clk1, rst_n : clock, async active-low reset
//   bus         : stream in, memory port, CPU hold/start/halted, result out
//   err         : sticky length-overflow / timeout flag
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | wait for count high byte
// LEN_LO   | wait for count low byte, range-check N
// BYTES    | collect 4 bytes of the current word
// WRITE    | one-cycle memory write of the assembled word
// START    | cpu_start pulse, CPU released
// RUN      | CPU running, watch halt and timeout
// READ     | address RESULT_ADDR, capture read data next cycle
// RESP     | hold result until accepted
// ERR      | terminal error until reset
module mips32_prog_loader
    import mips32_boot_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int MAX_WORDS   = 1024,
    parameter int RESULT_ADDR = 198,
    parameter int TIMEOUT     = 4000
) (
    input  logic                clk1,
    input  logic                rst_n,
    mips32_prog_loader_if.master bus,
    output logic                err
);

    localparam int IW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    // The counter starts one cycle after the cpu_start pulse and err is
    // registered, so leaving RUN at TIMEOUT-2 lands err exactly TIMEOUT
    // cycles after the pulse.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);
    localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT);

    loader_state_t state;
    logic [7:0]    len_hi;
    logic [15:0]   len_full;
    logic [IW-1:0] len;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          rd_wait;
    logic          in_hs;
    logic          pk_ready;
    logic          pk_valid;
    logic [31:0]   pk_word;

    assign in_hs    = bus.in_valid && bus.in_ready;
    assign len_full = {len_hi, bus.in_data};
    assign idx_nxt  = idx + IW'(1);
    assign pk_ready = bus.in_ready && (state == ST_BYTES);

    mips32_byte_packer u_packer (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .byte_valid (bus.in_valid),
        .byte_ready (pk_ready),
        .byte_data  (bus.in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_hold  <= 1'b1;
            bus.cpu_start <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            err           <= 1'b0;
            len_hi        <= '0;
            len           <= '0;
            idx           <= '0;
            tmo_cnt       <= '0;
            rd_wait       <= 1'b0;
        end else begin
            bus.mem_we    <= 1'b0;
            bus.cpu_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.in_ready <= 1'b1;
                    bus.cpu_hold <= 1'b1;
                    if (in_hs) begin
                        len_hi <= bus.in_data;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (in_hs) begin
                        if (len_full == 16'd0) begin
                            bus.in_ready  <= 1'b0;
                            bus.cpu_hold  <= 1'b0;
                            bus.cpu_start <= 1'b1;
                            state         <= ST_START;
                        end else if (int'(len_full) > MAX_WORDS) begin
                            bus.in_ready <= 1'b0;
                            err          <= 1'b1;
                            state        <= ST_ERR;
                        end else begin
                            len   <= IW'(len_full);
                            idx   <= '0;
                            state <= ST_BYTES;
                        end
                    end
                end
                ST_BYTES: begin
                    if (pk_valid) begin
                        bus.in_ready  <= 1'b0;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= idx[ADDR_W-1:0];
                        bus.mem_wdata <= pk_word;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    idx <= idx_nxt;
                    if (idx_nxt == len) begin
                        bus.cpu_hold  <= 1'b0;
                        bus.cpu_start <= 1'b1;
                        state         <= ST_START;
                    end else begin
                        bus.in_ready <= 1'b1;
                        state        <= ST_BYTES;
                    end
                end
                ST_START: begin
                    tmo_cnt <= '0;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    // tmo_cnt==0 marks the first RUN cycle, where HALTED may
                    // still show the value from before the start pulse.
                    if ((tmo_cnt != '0) && bus.cpu_halted) begin
                        bus.cpu_hold <= 1'b1;
                        bus.mem_addr <= ADDR_W'(RESULT_ADDR);
                        rd_wait      <= 1'b0;
                        state        <= ST_READ;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.cpu_hold <= 1'b1;
                        err          <= 1'b1;
                        state        <= ST_ERR;
                    end else if (tmo_cnt != TMO_SAT) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_READ: begin
                    if (!rd_wait) begin
                        rd_wait <= 1'b1;
                    end else begin
                        bus.res_data  <= bus.mem_rdata;
                        bus.res_valid <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    err          <= 1'b1;
                    bus.cpu_hold <= 1'b1;
                    bus.in_ready <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: byte-stream source, synchronous memory and a
// small instruction-level MIPS32 model acting as the CPU.
module tb_mips32_prog_loader;
    import mips32_boot_pkg::*;

    localparam int ADDR_W      = 10;
    localparam int RESULT_ADDR = 198;
    localparam int TIMEOUT     = 4000;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;
    logic err;

    always #5 clk1 = ~clk1;

    mips32_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips32_prog_loader #(
        .ADDR_W(ADDR_W), .MAX_WORDS(1024), .RESULT_ADDR(RESULT_ADDR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus.master),
        .err   (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory + CPU model ----------------
    logic [31:0] mem  [0:1023];
    logic [31:0] regs [0:31];
    logic [9:0]  pc = '0;
    logic        halted_r = 1'b1;
    int          cpu_mode = 0;   // 0: execute program, 1: halt at once, 2: never halt
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    assign bus.cpu_halted = halted_r;

    always @(posedge clk1) begin : mem_cpu
        logic [31:0] ins, a, b, imm;
        logic [9:0]  ea;
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (poke_en) mem[poke_addr] <= poke_data;
        if (bus.cpu_start) begin
            pc       <= '0;
            halted_r <= 1'b0;
        end else if (!bus.cpu_hold && !halted_r) begin
            if (cpu_mode == 1) begin
                halted_r <= 1'b1;
            end else if (cpu_mode == 0) begin
                ins = mem[pc];
                a   = (ins[25:21] == 5'd0) ? 32'd0 : regs[ins[25:21]];
                b   = (ins[20:16] == 5'd0) ? 32'd0 : regs[ins[20:16]];
                imm = {{16{ins[15]}}, ins[15:0]};
                ea  = a[9:0] + imm[9:0];
                pc <= pc + 10'd1;
                case (ins[31:26])
                    6'h00: regs[ins[15:11]] <= a + b;
                    6'h01: regs[ins[15:11]] <= a - b;
                    6'h03: regs[ins[15:11]] <= a | b;
                    6'h05: regs[ins[15:11]] <= a * b;
                    6'h08: regs[ins[20:16]] <= mem[ea];
                    6'h09: mem[ea] <= b;
                    6'h0a: regs[ins[20:16]] <= a + imm;
                    6'h0b: regs[ins[20:16]] <= a - imm;
                    6'h0d: if (a != 0) pc <= pc + 10'd1 + imm[9:0];
                    6'h0e: if (a == 0) pc <= pc + 10'd1 + imm[9:0];
                    6'h3f: halted_r <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    logic [9:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int         wr_cyc_q  [$];
    int         start_cnt = 0;
    int         start_cyc = 0;
    int         err_cyc   = -1;
    logic       err_prev  = 1'b0;

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (bus.mem_we) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.cpu_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (err && !err_prev) err_cyc <= cyc;
        err_prev <= err;
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] prog [$];

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit ok;
        ok  = 0;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) @(negedge clk1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 100; t++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk1);
        end
        if (!ok) check("in_ready_wait", 0, 1);
        @(negedge clk1);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic send_header(input logic [15:0] n, input int max_gap);
        for (int i = HDR_BYTES - 1; i >= 0; i--) send_byte(8'(n >> (8 * i)), max_gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int j = BYTES_PER_WORD - 1; j >= 0; j--) send_byte(8'(w >> (8 * j)), max_gap);
    endtask

    task automatic send_words(input int max_gap);
        for (int i = 0; i < prog.size(); i++) send_word(prog[i], max_gap);
    endtask

    task automatic check_writes(input string tag, input int base);
        check({tag, "_nwr"}, wr_addr_q.size() - base, prog.size());
        for (int i = 0; i < prog.size(); i++) begin
            if (base + i < wr_addr_q.size()) begin
                check({tag, "_wr_addr"}, wr_addr_q[base + i], i);
                check({tag, "_wr_data"}, wr_data_q[base + i], prog[i]);
            end
        end
    endtask

    task automatic wait_res(input string tag, input int budget);
        int t;
        t = 0;
        while (!bus.res_valid && t < budget) begin
            @(negedge clk1);
            t++;
        end
        if (!bus.res_valid) check({tag, "_res_timeout"}, 0, 1);
    endtask

    task automatic accept_result(input string tag);
        bus.res_ready = 1'b1;
        @(negedge clk1);
        bus.res_ready = 1'b0;
        check({tag, "_valid_drop"}, bus.res_valid, 0);
        check({tag, "_hold_back"}, bus.cpu_hold, 1);
        @(negedge clk1);
    endtask

    task automatic poke(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk1);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        @(negedge clk1);
        poke_en = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  bus.in_ready, 0);
        check({tag, "_mem_we"},    bus.mem_we, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_cpu_hold"},  bus.cpu_hold, 1);
        check({tag, "_cpu_start"}, bus.cpu_start, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_data"},  bus.res_data, 0);
        check({tag, "_err"},       err, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int base, s0, hs, t;
        logic [31:0] r;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.res_ready = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        check_reset_outputs("rst");
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);

        // factorial of Mem[200]=8, result stored at 198
        prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                 32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                 32'h3460fffc, 32'h2542fffe, HLT_OPCODE};
        poke(10'd200, 32'd8);
        cpu_mode = 0;
        base = wr_addr_q.size();
        s0   = start_cnt;
        send_header(16'(prog.size()), 0);
        send_words(0);
        wait_res("fact", 1000);
        repeat (2) @(negedge clk1);
        check("fact_res_data", bus.res_data, 32'd40320);
        check("fact_err", err, 0);
        check("fact_starts", start_cnt - s0, 1);
        check_writes("fact", base);
        if (wr_cyc_q.size() >= base + 11)
            check("fact_pace", wr_cyc_q[base + 10] - wr_cyc_q[base], 50);
        accept_result("fact");

        // zero-length program
        r = $urandom;
        poke(10'(RESULT_ADDR), r);
        cpu_mode = 1;
        base = wr_addr_q.size();
        s0   = start_cnt;
        send_header(16'h0000, 0);
        hs = cyc;
        wait_res("zero", 100);
        repeat (2) @(negedge clk1);
        check("zero_nwr", wr_addr_q.size() - base, 0);
        check("zero_starts", start_cnt - s0, 1);
        check("zero_start_lat", (start_cyc >= hs) && (start_cyc - hs <= 2), 1);
        check("zero_res_data", bus.res_data, r);
        accept_result("zero");

        // oversize header
        base = wr_addr_q.size();
        send_header(16'h0401, 0);
        repeat (3) @(negedge clk1);
        check("ovf_err", err, 1);
        check("ovf_in_ready", bus.in_ready, 0);
        check("ovf_hold", bus.cpu_hold, 1);
        repeat (20) @(negedge clk1);
        check("ovf_err_sticky", err, 1);
        check("ovf_hold_sticky", bus.cpu_hold, 1);
        check("ovf_in_ready_sticky", bus.in_ready, 0);
        check("ovf_nwr", wr_addr_q.size() - base, 0);
        do_reset();
        check("ovf_err_cleared", err, 0);

        // CPU never halts
        cpu_mode = 2;
        prog = '{$urandom};
        send_header(16'd1, 0);
        send_words(0);
        t = 0;
        while (!err && t < TIMEOUT + 200) begin
            @(negedge clk1);
            t++;
        end
        if (!err) check("tmo_err_timeout", 0, 1);
        repeat (2) @(negedge clk1);
        check("tmo_latency", err_cyc - start_cyc, TIMEOUT);
        check("tmo_hold", bus.cpu_hold, 1);
        check("tmo_res_valid", bus.res_valid, 0);
        do_reset();

        // stream gaps and a stalled result sink
        prog = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        r = $urandom;
        poke(10'(RESULT_ADDR), r);
        cpu_mode = 1;
        base = wr_addr_q.size();
        send_header(16'(prog.size()), 3);
        send_words(3);
        wait_res("gap", 200);
        check_writes("gap", base);
        for (int i = 0; i < prog.size(); i++) check("gap_mem_image", mem[i], prog[i]);
        for (int i = 0; i < 20; i++) begin
            check("gap_stall_valid", bus.res_valid, 1);
            check("gap_stall_data", bus.res_data, r);
            @(negedge clk1);
        end
        accept_result("gap");

        // reset in the middle of word 3
        prog = '{$urandom, $urandom, $urandom, $urandom, $urandom};
        send_header(16'd5, 0);
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        send_byte(8'(prog[2] >> 24), 0);
        send_byte(8'(prog[2] >> 16), 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        prog = '{$urandom, $urandom};
        r = $urandom;
        poke(10'(RESULT_ADDR), r);
        cpu_mode = 1;
        base = wr_addr_q.size();
        send_header(16'd2, 0);
        send_words(0);
        wait_res("reload", 200);
        check_writes("reload", base);
        check("reload_res_data", bus.res_data, r);
        accept_result("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Upstream companion to pipe_MIPS32: receives a program as a byte stream, writes it word-by-word into the CPU's shared instruction/data memory, then releases the CPU.
- Watches the CPU halt flag, reads one result word from a fixed memory address, and returns it over a valid/ready handshake.
- Replaces bench-side hierarchical pokes (Mem[], PC, HALTED, TAKEN_BRANCH) with a synthesizable boot/readback path.

Parameters:
- ADDR_W, 10, memory word-address width.
- MAX_WORDS, 1024, largest accepted program length in words; must be <= 2**ADDR_W.
- RESULT_ADDR, 198, word address read back after halt.
- TIMEOUT, 4000, maximum cycles in RUN before an error is flagged.

Ports:
- clk1  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte-stream valid.
- in_ready  out  1  byte-stream ready.
- in_data  in  8  stream byte.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  memory word address (write or read).
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid one cycle after mem_addr is presented with mem_we=0.
- cpu_hold  out  1  holds the CPU frozen (HALTED forced) while high.
- cpu_start  out  1  one-cycle pulse: CPU sets PC=0, HALTED=0, TAKEN_BRANCH=0.
- cpu_halted  in  1  CPU HALTED flag.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  32  word read from RESULT_ADDR.
- err  out  1  sticky error (length overflow or timeout); cleared only by reset.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - cpu_hold=1; in_ready, mem_we, cpu_start, res_valid and err all 0.
  - mem_addr=0, mem_wdata=0, res_data=0; all counters 0.
  - A reset mid-load leaves any partially written memory as-is; the next stream starts a fresh load at address 0.
- Stream format: 2-byte big-endian word count N, then 4*N bytes, each word big-endian. Word k is written to address k.
- States:
  - IDLE: in_ready=1; a byte handshake latches the count high byte -> LEN_LO.
  - LEN_LO: byte handshake completes N. If N==0 -> START; if N>MAX_WORDS -> ERR; else -> BYTES.
  - BYTES: in_ready=1; shift bytes into a 32-bit assembly register; 2-bit byte counter. The 4th byte -> WRITE.
  - WRITE: in_ready=0; mem_we=1 for exactly one cycle; mem_addr=word index; mem_wdata=assembled word. Then increment the index; if index==N -> START, else -> BYTES.
  - START: cpu_hold=0; cpu_start=1 for one cycle; clear the timeout counter -> RUN.
  - RUN: cpu_hold=0. The halt sample is ignored in the first RUN cycle (the HALTED clear has not yet propagated). From the second cycle on, cpu_halted=1 -> READ. If the counter reaches TIMEOUT -> ERR.
  - READ: mem_addr=RESULT_ADDR, mem_we=0; wait one cycle, capture mem_rdata into res_data -> RESP.
  - RESP: res_valid=1, with res_data held stable until res_ready. Handshake -> IDLE with cpu_hold=1.
  - ERR: err=1, cpu_hold=1, in_ready=0; terminal until reset.
- Stream timing: in_valid without in_ready must be held by the source; no byte is dropped or duplicated. Gaps in in_valid are allowed in any loading state.
- Throughput: 5 cycles per word minimum (4 bytes plus 1 write cycle).
- cpu_hold=1 in every state except START and RUN.
- Width rules: the word index is ADDR_W+1 bits so N==MAX_WORDS terminates without wrap. The timeout counter saturates at TIMEOUT.

Decomposition:
- Shared package mips32_boot_pkg holds:
  - the state enum;
  - localparams HDR_BYTES=2, BYTES_PER_WORD=4;
  - the HLT opcode constant 32'hfc000000 for benches.
- One sub-module, mips32_byte_packer: an 8-to-32 big-endian assembler with valid/ready in and a one-cycle word_valid out, reusable for later data-segment loaders.

Test Plan:
- Factorial program (11 words: 280a00c8 ... fc000000) plus a separate poke of Mem[200]=8; CPU model runs -> 11 mem_we pulses at addresses 0..10, one cpu_start, res_data=40320 from addr 198, err=0.
- Header 0x0000 -> no mem_we, cpu_start within 2 cycles of the second byte; a CPU model halting immediately -> RESP with the word at RESULT_ADDR.
- Header 0x0401 (1025 > MAX_WORDS) -> err=1, in_ready=0, no mem_we, cpu_hold=1 until reset.
- Stub CPU never halts -> err rises exactly TIMEOUT cycles after cpu_start; cpu_hold returns to 1.
- Random in_valid gaps plus res_ready held low for 20 cycles -> identical memory image; res_data stable and res_valid high throughout the stall.
- rst_n dropped during BYTES of word 3 -> outputs reach reset values asynchronously; a subsequent full 2-word stream writes addresses 0 and 1 correctly.
